// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory bus of cpu_core between the instruction-fetch port
// and the load/store data port. One requester is granted at a time. With both
// requesting, the port not granted last wins. The bus strobes are held until
// bus_full is sampled high. After that, a one-cycle ack returns the captured
// read data.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES busy cycles without a response. The abort completes with
// ack, rdata = 0 and bus_error = 1. Without the macro, busy states wait
// indefinitely and bus_error is tied 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_req/i_addr      fetch request and address (req held until i_ack)
//   i_rdata/i_ack     fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   data request (d_we = 1 store, 0 load)
//   d_rdata/d_ack     load data and one-cycle completion pulse
//   address_out, data_out_BUS, bus_read, bus_write   bus command side
//   data_in_BUS, bus_full                            bus response side
//   instr_wait        core stall while any request is outstanding
//   bus_error         timeout pulse, coincident with the ack
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out_BUS,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [DATA_W-1:0] data_in_BUS,
    input  logic              bus_full,
    output logic              instr_wait,
    output logic              bus_error
);

    // state  | meaning
    // IDLE   | no transaction, waiting for a request
    // BUSY_I | fetch on the bus, waiting for bus_full
    // BUSY_D | load/store on the bus, waiting for bus_full
    // RESP   | one-cycle ack to the granted port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // last_d doubles as the current-grant flag: it is written only on a grant,
    // so in BUSY/RESP it names the port being served.
    logic              last_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic grant_d, grant_i;
    logic busy;
    logic timeout_hit;
    logic err_q;

    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    // With both requesting, data wins unless data was the last grant.
    assign grant_d = (state == IDLE) && d_req && (!i_req || !last_d);
    assign grant_i = (state == IDLE) && i_req && !grant_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt;

    // Down-counter loaded on grant. Terminal count in a busy cycle without a
    // response is the TIMEOUT_CYCLES-th silent cycle. A response in that same
    // cycle takes priority.
    assign timeout_hit = busy && !bus_full && (tmo_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
                err_q   <= 1'b0;
            end else if (busy) begin
                if (!bus_full && (tmo_cnt != '0))
                    tmo_cnt <= tmo_cnt - 1'b1;
                err_q <= timeout_hit;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_nxt = BUSY_D;
                else if (grant_i)
                    state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (bus_full || timeout_hit)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches, grant pointer and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (grant_d) begin
                last_d  <= 1'b1;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else if (grant_i) begin
                last_d  <= 1'b0;
                addr_q  <= i_addr;
                we_q    <= 1'b0;
            end

            if (state == BUSY_I) begin
                if (bus_full)
                    i_rdata <= data_in_BUS;
                else if (timeout_hit)
                    i_rdata <= '0;
            end

            if (state == BUSY_D) begin
                if (bus_full) begin
                    if (!we_q)
                        d_rdata <= data_in_BUS;
                end else if (timeout_hit) begin
                    d_rdata <= '0;
                end
            end
        end
    end

    // Outputs decoded from registered state and latches only, so the strobes
    // stay stable for the whole busy interval.
    always_comb begin
        address_out  = '0;
        data_out_BUS = '0;
        bus_read     = 1'b0;
        bus_write    = 1'b0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        bus_error    = 1'b0;
        case (state)
            BUSY_I: begin
                address_out = addr_q;
                bus_read    = 1'b1;
            end
            BUSY_D: begin
                address_out = addr_q;
                if (we_q) begin
                    bus_write    = 1'b1;
                    data_out_BUS = wdata_q;
                end else begin
                    bus_read = 1'b1;
                end
            end
            RESP: begin
                i_ack     = !last_d;
                d_ack     = last_d;
                bus_error = err_q;
            end
            default: ;
        endcase
    end

    assign instr_wait = (i_req | d_req) & ~(i_ack | d_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    typedef struct {
        bit          port_d;
        logic [31:0] rdata;
        bit          chk_rd;
        bit          err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] address_out;
    logic [31:0] data_out_BUS;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] data_in_BUS;
    logic        bus_full;
    logic        instr_wait;
    logic        bus_error;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int i_acks = 0;
    int d_acks = 0;
    int busy_cnt = 0;
    int lat = 1;          // busy cycle in which bus_full is raised; 0 = never
    bit force_full = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;

    mem_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_ack(i_ack),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ack(d_ack),
        .address_out(address_out),
        .data_out_BUS(data_out_BUS),
        .bus_read(bus_read),
        .bus_write(bus_write),
        .data_in_BUS(data_in_BUS),
        .bus_full(bus_full),
        .instr_wait(instr_wait),
        .bus_error(bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0030_0093 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit port_d, input logic [31:0] rdata, input bit chk_rd, input bit err);
        exp_t e;
        e.port_d = port_d;
        e.rdata  = rdata;
        e.chk_rd = chk_rd;
        e.err    = err;
        sb.push_back(e);
    endtask

    // One cycle: observe outputs at the falling edge, score acks, drop the
    // acked request, then update the bus responder for the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus_read) begin
            rd_cycles++;
            last_addr = address_out;
        end
        if (bus_write) begin
            wr_cycles++;
            last_addr  = address_out;
            last_wdata = data_out_BUS;
        end
        chk("instr_wait", {63'd0, instr_wait}, {63'd0, (i_req | d_req) & ~(i_ack | d_ack)});
        if (i_ack && d_ack)
            chk("dual_ack", 64'd1, 64'd0);
        if (i_ack || d_ack) begin
            if (i_ack) i_acks++;
            if (d_ack) d_acks++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {63'd0, d_ack}, {63'd0, e.port_d});
                if (e.chk_rd)
                    chk("rdata", {32'd0, (d_ack ? d_rdata : i_rdata)}, {32'd0, e.rdata});
                chk("bus_error", {63'd0, bus_error}, {63'd0, e.err});
            end
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
        end else if (bus_error) begin
            chk("stray_error", 64'd1, 64'd0);
        end
        if (bus_read || bus_write) begin
            busy_cnt++;
            bus_full    = (lat != 0) && (busy_cnt == lat);
            data_in_BUS = bus_full ? mem(address_out) : 32'hDEAD_BEEF;
        end else begin
            busy_cnt    = 0;
            bus_full    = force_full;
            data_in_BUS = force_full ? 32'h1234_5678 : 32'h0;
        end
    endtask

    task automatic wait_acks(input int target, input int budget, output int n);
        n = 0;
        while ((i_acks + d_acks) < target && n < budget) begin
            tick();
            n++;
        end
        if ((i_acks + d_acks) < target)
            chk("ack_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int rd0, wr0, ia0, da0;

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        data_in_BUS = '0; bus_full = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_i_ack", {63'd0, i_ack}, 64'd0);
        chk("rst_d_ack", {63'd0, d_ack}, 64'd0);
        chk("rst_bus_read", {63'd0, bus_read}, 64'd0);
        chk("rst_bus_write", {63'd0, bus_write}, 64'd0);
        chk("rst_addr", {32'd0, address_out}, 64'd0);
        chk("rst_wdata", {32'd0, data_out_BUS}, 64'd0);
        chk("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
        chk("rst_d_rdata", {32'd0, d_rdata}, 64'd0);
        chk("rst_bus_error", {63'd0, bus_error}, 64'd0);
        rst = 1'b0;
        tick();

        // Contention straight after reset: data, instr, then data, instr again
        lat = 2;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        push(1'b1, mem(32'h300), 1'b1, 1'b0);
        push(1'b0, mem(32'h200), 1'b1, 1'b0);
        wait_acks(i_acks + d_acks + 2, 40, n);
        tick();
        i_req = 1'b1; i_addr = 32'h204;
        d_req = 1'b1; d_addr = 32'h304;
        push(1'b1, mem(32'h304), 1'b1, 1'b0);
        push(1'b0, mem(32'h204), 1'b1, 1'b0);
        wait_acks(i_acks + d_acks + 2, 40, n);
        tick();

        // Fetch with response in the 3rd busy cycle
        lat = 3;
        rd0 = rd_cycles; da0 = d_acks; ia0 = i_acks;
        i_req = 1'b1; i_addr = 32'h100;
        push(1'b0, 32'h0030_0093, 1'b1, 1'b0);
        wait_acks(i_acks + d_acks + 1, 20, n);
        chk("fetch_read_cycles", 64'(rd_cycles - rd0), 64'd3);
        chk("fetch_addr", {32'd0, last_addr}, 64'h100);
        chk("fetch_i_acks", 64'(i_acks - ia0), 64'd1);
        chk("fetch_no_d_ack", 64'(d_acks - da0), 64'd0);
        tick();
        tick();
        chk("fetch_rdata_hold", {32'd0, i_rdata}, 64'h0030_0093);

        // Store with response in the 1st busy cycle
        lat = 1;
        rd0 = rd_cycles; wr0 = wr_cycles;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0000_FFFF;
        push(1'b1, 32'h0, 1'b0, 1'b0);
        wait_acks(i_acks + d_acks + 1, 20, n);
        chk("store_latency", 64'(n), 64'd2);
        chk("store_write_cycles", 64'(wr_cycles - wr0), 64'd1);
        chk("store_no_read", 64'(rd_cycles - rd0), 64'd0);
        chk("store_wdata", {32'd0, last_wdata}, 64'h0000_FFFF);
        chk("store_addr", {32'd0, last_addr}, 64'h20);
        d_we = 1'b0;
        tick();

        // Reset in the 2nd busy cycle of a fetch
        lat = 0;
        rd0 = rd_cycles; ia0 = i_acks;
        i_req = 1'b1; i_addr = 32'h108;
        n = 0;
        while ((rd_cycles - rd0) < 2 && n < 10) begin
            tick();
            n++;
        end
        chk("midop_busy_reached", 64'(rd_cycles - rd0), 64'd2);
        rst = 1'b1;
        i_req = 1'b0;
        tick();
        chk("midop_bus_read", {63'd0, bus_read}, 64'd0);
        chk("midop_addr", {32'd0, address_out}, 64'd0);
        chk("midop_i_ack", {63'd0, i_ack}, 64'd0);
        chk("midop_i_rdata", {32'd0, i_rdata}, 64'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("midop_no_ack", 64'(i_acks - ia0), 64'd0);
        lat = 2;
        i_req = 1'b1; i_addr = 32'h104;
        push(1'b0, mem(32'h104), 1'b1, 1'b0);
        wait_acks(i_acks + d_acks + 1, 20, n);
        tick();

        // Spurious response in IDLE
        rd0 = rd_cycles; wr0 = wr_cycles; ia0 = i_acks; da0 = d_acks;
        force_full = 1'b1;
        tick();
        tick();
        tick();
        force_full = 1'b0;
        tick();
        tick();
        chk("spur_strobes", 64'((rd_cycles - rd0) + (wr_cycles - wr0)), 64'd0);
        chk("spur_acks", 64'((i_acks - ia0) + (d_acks - da0)), 64'd0);

        // Timeout behaviour
`ifdef ARB_TIMEOUT_EN
        lat = 0;
        rd0 = rd_cycles;
        i_req = 1'b1; i_addr = 32'h180;
        push(1'b0, 32'h0, 1'b1, 1'b1);
        wait_acks(i_acks + d_acks + 1, 20, n);
        chk("tmo_busy_cycles", 64'(rd_cycles - rd0), 64'd4);
        tick();
        // Response in the final counted cycle wins over the timeout
        lat = 4;
        rd0 = rd_cycles;
        i_req = 1'b1; i_addr = 32'h184;
        push(1'b0, mem(32'h184), 1'b1, 1'b0);
        wait_acks(i_acks + d_acks + 1, 20, n);
        chk("tmo_edge_busy_cycles", 64'(rd_cycles - rd0), 64'd4);
        tick();
`else
        lat = 0;
        ia0 = i_acks;
        i_req = 1'b1; i_addr = 32'h180;
        repeat (100) tick();
        chk("hang_bus_read", {63'd0, bus_read}, 64'd1);
        chk("hang_bus_error", {63'd0, bus_error}, 64'd0);
        chk("hang_no_ack", 64'(i_acks - ia0), 64'd0);
        rst = 1'b1;
        i_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory bus of `cpu_core` between the instruction-fetch port and the load/store data port. It grants one requester at a time, drives the bus strobes, and waits for the `bus_full` response. It returns read data with a one-cycle acknowledge and stalls the core through `instr_wait` while any request is outstanding. It sits between the core's fetch/LSU logic and the external memory bus.

## Interface
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width
- `TIMEOUT_CYCLES`, 16, busy cycles before a transaction is aborted (used only with `ARB_TIMEOUT_EN`)

One clock; reset is synchronous and active-high.

- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `i_req`  in  1  instruction fetch request, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetched instruction, valid while `i_ack`
- `i_ack`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`
- `d_ack`  out  1  one-cycle data completion pulse
- `address_out`  out  ADDR_W  bus address
- `data_out_BUS`  out  DATA_W  bus write data
- `bus_read`  out  1  bus read strobe
- `bus_write`  out  1  bus write strobe
- `data_in_BUS`  in  DATA_W  bus read data
- `bus_full`  in  1  bus response; transaction complete when sampled high
- `instr_wait`  out  1  core stall
- `bus_error`  out  1  timeout pulse, coincident with ack

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Only `d_req` high → BUSY_D. Only `i_req` high → BUSY_I.
  - Both high → round-robin: grant the port not granted last. The last-grant pointer resets to "instruction", so data wins first.
  - On grant, latch address, and for data also `d_we` and `d_wdata`.
- BUSY_I: `bus_read`=1, `address_out`=latched `i_addr`. `bus_full` high at an edge → capture `data_in_BUS` into `i_rdata` → RESP.
- BUSY_D, load: `bus_read`=1. Store: `bus_write`=1 and `data_out_BUS`=latched `d_wdata`. `bus_full` high → capture `data_in_BUS` into `d_rdata` (loads only) → RESP.
- RESP: the granted port's ack is high for exactly one cycle. Strobes are 0. Next state is IDLE. Requests are ignored in RESP.
- Requesters drop `req` on the edge ending their ack cycle. If `req` is still high in the next IDLE, it is a new request.
- In IDLE and RESP, `address_out`, `data_out_BUS`, `bus_read` and `bus_write` are 0.
- `bus_full` is ignored in IDLE and RESP.
- `i_rdata` and `d_rdata` hold their last captured value until the next capture.
- `instr_wait` = (`i_req` | `d_req`) & ~(`i_ack` | `d_ack`), combinational.
- Reset, including mid-transaction: state IDLE, pointer = instruction, all outputs 0. The in-flight transaction is dropped and no ack is issued.

## Timing
- Request high at edge E0 (IDLE) → strobes high from cycle E0+1.
- `bus_full` sampled high at edge Ek → ack high for the cycle after Ek.
- Minimum latency: `bus_full` high in the first busy cycle → ack two cycles after request sampling.
- Strobes are registered and stay stable for the whole busy interval.
- Back-to-back: after RESP there is at least one IDLE cycle before the next grant.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on grant and counts busy cycles with `bus_full` low.
  - After `TIMEOUT_CYCLES` such cycles → RESP with ack, rdata=0 and `bus_error`=1 for the ack cycle.
  - If `bus_full` is high in the final counted cycle, the response wins and no error is raised.
- Undefined: no counter; busy states wait indefinitely; `bus_error` tied 0.

## Test plan
- Fetch: `i_req`, `i_addr`=0x100; `bus_full` high in 3rd busy cycle with `data_in_BUS`=0x00300093 → `bus_read` high exactly 3 cycles, `address_out`=0x100, `i_ack` one cycle, `i_rdata`=0x00300093, `d_ack` never.
- Store: `d_we`=1, `d_addr`=0x20, `d_wdata`=0x0000FFFF; `bus_full` in 1st busy cycle → `bus_write`=1 with `data_out_BUS`=0x0000FFFF for 1 cycle, `d_ack` 2 cycles after request, `bus_read` never.
- Contention: `i_req` and `d_req` high together after reset → data served first, then fetch. Repeat both high → data, then instruction again (alternation); `instr_wait` low only in ack cycles.
- Reset mid-op: `rst` in 2nd BUSY_I cycle → next cycle all outputs 0, no `i_ack`; a subsequent fetch of 0x104 completes normally.
- Spurious response: `bus_full` pulsed in IDLE with no requests → no ack, strobes stay 0.
- Timeout: with `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `bus_full` held 0 → `i_ack` and `bus_error` together after 4 busy cycles, `i_rdata`=0. Without the macro → still busy after 100 cycles, `bus_error`=0.
